// File: rtl/delta_adc_pkg.sv
// Shared definitions for the delta ADC: state encoding and data width.
package delta_adc_pkg;

    localparam int ADC_WIDTH = 16;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] UPDATE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SETTLE = SETTLE,
        ST_SAMPLE = SAMPLE,
        ST_UPDATE = UPDATE
    } state_t;

endpackage

// File: rtl/delta_adc_fsm_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared by reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to resolve metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/delta_adc_fsm.sv
// Tracking FSM of the delta ADC: waits for the PWM/RC filter to settle,
// samples the comparator, steps the value up or down with saturation and
// flags lock once the loop keeps reversing direction.
module delta_adc_fsm
    import delta_adc_pkg::*;
#(
    parameter int WIDTH          = ADC_WIDTH,
    parameter int STEP           = 1,
    parameter int SETTLE_PERIODS = 2,
    parameter int LOCK_REVERSALS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             period_end,
    input  logic             comp_in,
    input  logic [WIDTH-1:0] cur_value,
    output logic [WIDTH-1:0] next_value,
    output logic             enable,
    output logic             busy,
    output logic             settled
);

    localparam int CNT_W = $clog2(SETTLE_PERIODS + 1);
    localparam int REV_W = $clog2(LOCK_REVERSALS + 1);

    localparam logic [WIDTH:0]     STEP_X      = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH:0]     MAX_X       = {1'b0, {WIDTH{1'b1}}};
    localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_PERIODS);
    localparam logic [REV_W-1:0]   REV_MAX     = REV_W'(LOCK_REVERSALS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]   settle_inc;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
    logic               last_dir_q, last_dir_d;
    logic               have_dir_q, have_dir_d;
    logic [WIDTH-1:0]   next_value_q, next_value_d;
    logic               enable_q, enable_d;
    logic               comp_s;

    logic [WIDTH:0]     cur_x;
    logic [WIDTH:0]     up_x;
    logic [WIDTH:0]     dn_x;
    logic [WIDTH-1:0]   step_value;

    sync_2ff u_comp_sync (
        .clk (clk),
        .rst (reset),
        .d   (comp_in),
        .q   (comp_s)
    );

    // Saturating step: the extra top bit catches overflow above MAX and borrow below 0.
    always_comb begin
        cur_x = {1'b0, cur_value};
        up_x  = cur_x + STEP_X;
        dn_x  = cur_x - STEP_X;
        if (comp_s) begin
            step_value = (up_x > MAX_X) ? MAX_X[WIDTH-1:0] : up_x[WIDTH-1:0];
        end else begin
            step_value = dn_x[WIDTH] ? '0 : dn_x[WIDTH-1:0];
        end
    end

    // Next-state, settle counting, lock tracking and update pulse generation.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        rev_cnt_d    = rev_cnt_q;
        last_dir_d   = last_dir_q;
        have_dir_d   = have_dir_q;
        next_value_d = next_value_q;
        enable_d     = 1'b0;
        settle_inc   = settle_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                rev_cnt_d  = '0;
                have_dir_d = 1'b0;
                if (start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!start) begin
                    state_d    = ST_IDLE;
                    rev_cnt_d  = '0;
                    have_dir_d = 1'b0;
                end else if (period_end) begin
                    if (settle_inc == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_cnt_d = settle_inc;
                    end
                end
            end
            ST_SAMPLE: begin
                next_value_d = step_value;
                enable_d     = 1'b1;
                state_d      = ST_UPDATE;
                // The first update after IDLE only establishes a direction.
                if (have_dir_q) begin
                    if (comp_s != last_dir_q) begin
                        rev_cnt_d = (rev_cnt_q == REV_MAX) ? rev_cnt_q : rev_cnt_q + 1'b1;
                    end else begin
                        rev_cnt_d = '0;
                    end
                end
                last_dir_d = comp_s;
                have_dir_d = 1'b1;
            end
            ST_UPDATE: begin
                if (start) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                    rev_cnt_d  = '0;
                    have_dir_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any update in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            rev_cnt_q    <= '0;
            last_dir_q   <= 1'b0;
            have_dir_q   <= 1'b0;
            next_value_q <= '0;
            enable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            rev_cnt_q    <= rev_cnt_d;
            last_dir_q   <= last_dir_d;
            have_dir_q   <= have_dir_d;
            next_value_q <= next_value_d;
            enable_q     <= enable_d;
        end
    end

    assign next_value = next_value_q;
    assign enable     = enable_q;
    assign busy       = (state_q != ST_IDLE);
    assign settled    = (rev_cnt_q >= REV_MAX);

endmodule

// File: tb/tb_delta_adc_fsm.sv
// Directed bench for delta_adc_fsm with a transaction-level reference model.
module tb_delta_adc_fsm;

    localparam int SP = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        period_end = 1'b0;
    logic        comp_in = 1'b0;
    logic [15:0] cur_value = 16'd0;
    logic [15:0] next_value;
    logic        enable, busy, settled;

    logic        start4 = 1'b0;
    logic        pe4 = 1'b0;
    logic        comp4 = 1'b0;
    logic [15:0] cur4 = 16'd0;
    logic [15:0] nv4;
    logic        en4, busy4, set4;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int value;
        int due;
        bit settled;
    } exp_t;

    exp_t exp_q[$];
    bit   dirs[$];

    delta_adc_fsm #(.WIDTH(16), .STEP(1), .SETTLE_PERIODS(SP), .LOCK_REVERSALS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .period_end(period_end),
        .comp_in(comp_in), .cur_value(cur_value), .next_value(next_value),
        .enable(enable), .busy(busy), .settled(settled)
    );

    delta_adc_fsm #(.WIDTH(16), .STEP(4), .SETTLE_PERIODS(SP), .LOCK_REVERSALS(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .period_end(pe4),
        .comp_in(comp4), .cur_value(cur4), .next_value(nv4),
        .enable(en4), .busy(busy4), .settled(set4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Plain-arithmetic saturating step on the full integer range.
    function automatic int model_step(input int cur, input bit up, input int step);
        int r;
        r = up ? cur + step : cur - step;
        if (r > 65535) r = 65535;
        if (r < 0) r = 0;
        return r;
    endfunction

    // Lock: count trailing alternations in the direction history since IDLE.
    function automatic bit model_settled();
        int rev = 0;
        for (int i = dirs.size() - 1; i >= 1; i--) begin
            if (dirs[i] != dirs[i-1]) rev++;
            else break;
        end
        return rev >= 4;
    endfunction

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end else begin
            $display("check %s = %0d ok (cyc %0d)", name, act, cyc);
        end
    endtask

    // Every cycle: enable must be high exactly when the model predicts an update.
    task automatic compare_loop();
        bit exp_en;
        forever begin
            @(negedge clk);
            if (!reset) begin
                exp_en = (exp_q.size() > 0) && (exp_q[0].due == cyc);
                checks++;
                if (enable !== exp_en) begin
                    errors++;
                    $display("FAIL enable cyc=%0d actual=%b expected=%b", cyc, enable, exp_en);
                end
                if (exp_en) begin
                    checks += 2;
                    if (int'(next_value) != exp_q[0].value) begin
                        errors++;
                        $display("FAIL next_value cyc=%0d actual=%0d expected=%0d", cyc, next_value, exp_q[0].value);
                    end
                    if (settled !== exp_q[0].settled) begin
                        errors++;
                        $display("FAIL settled cyc=%0d actual=%b expected=%b", cyc, settled, exp_q[0].settled);
                    end
                    $display("update cyc=%0d next_value=%0d settled=%b", cyc, next_value, settled);
                    void'(exp_q.pop_front());
                end
            end
        end
    endtask

    // One update: hold cur/comp, send SP period_end pulses, predict the pulse.
    task automatic do_update(input int cur, input bit comp, input bit late_toggle,
                             input bit pe_in_update, input bit drop_in_sample);
        exp_t e;
        cur_value = cur[15:0];
        comp_in   = comp;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < SP; k++) begin
            period_end = 1'b1;
            if (k == SP - 1) begin
                dirs.push_back(comp);
                e.value   = model_step(cur, comp, 1);
                e.due     = cyc + 2;
                e.settled = model_settled();
                exp_q.push_back(e);
                if (late_toggle) comp_in = ~comp;
            end
            @(posedge clk);
            #1;
            period_end = 1'b0;
            if (k == SP - 1) begin
                if (drop_in_sample) start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        if (pe_in_update) begin
            period_end = 1'b1;
            @(posedge clk);
            #1;
            period_end = 1'b0;
        end
        if (drop_in_sample) dirs.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int cur;
        bit c;
        int n;
        fork
            compare_loop();
        join_none

        // Reset state
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_lit("reset_next_value", int'(next_value), 0);
        check_lit("reset_enable", int'(enable), 0);
        check_lit("reset_busy", int'(busy), 0);
        check_lit("reset_settled", int'(settled), 0);
        reset = 1'b0;
        start = 1'b1;

        // Basic step up from 100
        do_update(100, 1'b1, 1'b0, 1'b0, 1'b0);
        check_lit("step_up_100", int'(next_value), 101);
        check_lit("busy_in_settle", int'(busy), 1);

        // Async reset mid-cycle while in SETTLE
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_lit("async_rst_next_value", int'(next_value), 0);
        check_lit("async_rst_enable", int'(enable), 0);
        check_lit("async_rst_busy", int'(busy), 0);
        check_lit("async_rst_settled", int'(settled), 0);
        dirs.delete();
        @(posedge clk);
        #1 reset = 1'b0;

        // Saturation at both rails
        do_update(65535, 1'b1, 1'b0, 1'b0, 1'b0);
        check_lit("sat_top", int'(next_value), 65535);
        do_update(0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_lit("sat_bottom", int'(next_value), 0);

        // Drop start during SETTLE after one pulse: no enable, back to idle
        period_end = 1'b1;
        @(posedge clk);
        #1 period_end = 1'b0;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_lit("drop_settle_busy", int'(busy), 0);
        dirs.delete();
        start = 1'b1;

        // Alternating directions: lock after 5 updates
        cur = 1000;
        for (int i = 0; i < 5; i++) begin
            c = (i % 2 == 0);
            do_update(cur, c, 1'b0, 1'b0, 1'b0);
            cur = model_step(cur, c, 1);
        end
        check_lit("settled_after_5", int'(settled), 1);
        for (int i = 0; i < 2; i++) begin
            do_update(cur, 1'b1, 1'b0, 1'b0, 1'b0);
            cur = model_step(cur, 1'b1, 1);
        end
        check_lit("settled_after_same", int'(settled), 0);
        check_lit("value_after_same", int'(next_value), 1003);
        for (int i = 0; i < 4; i++) begin
            c = (i % 2 == 1);
            do_update(cur, c, 1'b0, 1'b0, 1'b0);
            cur = model_step(cur, c, 1);
        end
        check_lit("settled_relock", int'(settled), 1);

        // Late comparator toggle uses old value; period_end in UPDATE ignored
        do_update(cur, 1'b0, 1'b1, 1'b1, 1'b0);
        check_lit("late_toggle_value", int'(next_value), 1002);
        cur = model_step(cur, 1'b0, 1);
        do_update(cur, 1'b1, 1'b0, 1'b0, 1'b0);
        cur = model_step(cur, 1'b1, 1);

        // Drop start during SAMPLE: one update completes, then idle
        do_update(cur, 1'b0, 1'b0, 1'b0, 1'b1);
        check_lit("drop_sample_value", int'(next_value), 1002);
        check_lit("drop_sample_busy", int'(busy), 0);
        check_lit("drop_sample_settled", int'(settled), 0);

        // STEP=4 instance: 2 - 4 saturates to 0, single pulse
        cur4 = 16'd2;
        comp4 = 1'b0;
        start4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < SP; k++) begin
            pe4 = 1'b1;
            @(posedge clk);
            #1 pe4 = 1'b0;
            @(posedge clk);
            #1;
        end
        n = 0;
        start4 = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (en4) n++;
        end
        check_lit("step4_pulses", n, 1);
        check_lit("step4_value", int'(nv4), 0);

        repeat (4) @(posedge clk);
        check_lit("pending_updates", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
